// File: rtl/idex_pipe_reg_pkg.sv
// idex_pipe_reg_pkg: shared RV32 pipeline constants and the ID/EX control bundle
package idex_pipe_reg_pkg;
  localparam int DEF_XLEN = 32;
  localparam int REG_W = 5;
  localparam logic [1:0] ALUOP_ITYPE = 2'b11;
  localparam logic STALL_BUBBLE = 1'b0;
  typedef struct packed {
    logic [2:0] funct3;
    logic       funct7b5;
    logic [1:0] alu_op;
    logic       alu_src;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       mem_to_reg;
    logic       branch;
  } ctrl_t;
endpackage

// File: rtl/idex_pipe_reg_sat_counter.sv
// sat_counter: sync-reset up counter that holds at all-ones (clk, rst, inc -> count)
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);
  logic [CNT_W-1:0] count_d, count_q;
  always_comb count_d = (inc && !(&count_q)) ? count_q + 1'b1 : count_q;
  always_ff @(posedge clk) count_q <= rst ? '0 : count_d;
  assign count = count_q;
endmodule

// File: rtl/idex_pipe_reg.sv
// idex_pipe_reg: ID/EX register with bubble/flush zeroing, WB bypass and saturating bubble/flush counters
module idex_pipe_reg
  import idex_pipe_reg_pkg::*;
#(
  parameter int XLEN  = DEF_XLEN,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             flush,
  input  logic             id_valid,
  input  logic [XLEN-1:0]  id_pc,
  input  logic [XLEN-1:0]  id_rs1_data,
  input  logic [XLEN-1:0]  id_rs2_data,
  input  logic [XLEN-1:0]  id_imm,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic [REG_W-1:0] id_rd,
  input  logic [2:0]       id_funct3,
  input  logic             id_funct7b5,
  input  logic [1:0]       id_ALUOp,
  input  logic             id_ALUSrc,
  input  logic             id_MemRead,
  input  logic             id_MemWrite,
  input  logic             id_RegWrite,
  input  logic             id_MemtoReg,
  input  logic             id_Branch,
  input  logic             wb_RegWrite,
  input  logic [REG_W-1:0] wb_rd,
  input  logic [XLEN-1:0]  wb_data,
  output logic             idex_valid,
  output logic [XLEN-1:0]  idex_pc,
  output logic [XLEN-1:0]  idex_rs1_data,
  output logic [XLEN-1:0]  idex_rs2_data,
  output logic [XLEN-1:0]  idex_imm,
  output logic [REG_W-1:0] idex_rs1,
  output logic [REG_W-1:0] idex_rs2,
  output logic [REG_W-1:0] idex_rd,
  output logic [2:0]       idex_funct3,
  output logic             idex_funct7b5,
  output logic [1:0]       idex_ALUOp,
  output logic             idex_ALUSrc,
  output logic             idex_MemRead,
  output logic             idex_MemWrite,
  output logic             idex_RegWrite,
  output logic             idex_MemtoReg,
  output logic             idex_Branch,
  output logic [CNT_W-1:0] bubble_cnt,
  output logic [CNT_W-1:0] flush_cnt
);
  logic             valid_d, valid_q;
  logic [XLEN-1:0]  pc_d, pc_q, rs1_data_d, rs1_data_q, rs2_data_d, rs2_data_q, imm_d, imm_q;
  logic [REG_W-1:0] rs1_d, rs1_q, rs2_d, rs2_q, rd_d, rd_q;
  ctrl_t            ctrl_d, ctrl_q, ctrl_in;
  logic             bubble, zero, byp1, byp2;
  always_comb begin
    bubble     = !flush && stall == STALL_BUBBLE;
    zero       = flush || bubble;
    byp1       = wb_RegWrite && wb_rd != '0 && wb_rd == id_rs1;
    byp2       = wb_RegWrite && wb_rd != '0 && wb_rd == id_rs2;
    ctrl_in    = '{funct3: id_funct3, funct7b5: id_funct7b5, alu_op: id_ALUOp, alu_src: id_ALUSrc,
                   mem_read: id_MemRead, mem_write: id_MemWrite, reg_write: id_RegWrite,
                   mem_to_reg: id_MemtoReg, branch: id_Branch};
    valid_d    = zero ? 1'b0 : id_valid;
    pc_d       = zero ? '0 : id_pc;
    rs1_data_d = zero ? '0 : byp1 ? wb_data : id_rs1_data;
    rs2_data_d = zero ? '0 : byp2 ? wb_data : id_rs2_data;
    imm_d      = zero ? '0 : id_imm;
    rs1_d      = zero ? '0 : id_rs1;
    rs2_d      = zero ? '0 : id_rs2;
    rd_d       = zero ? '0 : id_rd;
    ctrl_d     = zero ? '0 : ctrl_in;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q    <= 1'b0;
      pc_q       <= '0;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
      imm_q      <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      rd_q       <= '0;
      ctrl_q     <= '0;
    end else begin
      valid_q    <= valid_d;
      pc_q       <= pc_d;
      rs1_data_q <= rs1_data_d;
      rs2_data_q <= rs2_data_d;
      imm_q      <= imm_d;
      rs1_q      <= rs1_d;
      rs2_q      <= rs2_d;
      rd_q       <= rd_d;
      ctrl_q     <= ctrl_d;
    end
  end
  sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (.clk(clk), .rst(rst), .inc(bubble), .count(bubble_cnt));
  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt  (.clk(clk), .rst(rst), .inc(flush),  .count(flush_cnt));
  assign idex_valid    = valid_q;
  assign idex_pc       = pc_q;
  assign idex_rs1_data = rs1_data_q;
  assign idex_rs2_data = rs2_data_q;
  assign idex_imm      = imm_q;
  assign idex_rs1      = rs1_q;
  assign idex_rs2      = rs2_q;
  assign idex_rd       = rd_q;
  assign idex_funct3   = ctrl_q.funct3;
  assign idex_funct7b5 = ctrl_q.funct7b5;
  assign idex_ALUOp    = ctrl_q.alu_op;
  assign idex_ALUSrc   = ctrl_q.alu_src;
  assign idex_MemRead  = ctrl_q.mem_read;
  assign idex_MemWrite = ctrl_q.mem_write;
  assign idex_RegWrite = ctrl_q.reg_write;
  assign idex_MemtoReg = ctrl_q.mem_to_reg;
  assign idex_Branch   = ctrl_q.branch;
endmodule

// File: tb/tb_idex_pipe_reg.sv
// tb_idex_pipe_reg: directed self-checking bench for idex_pipe_reg (CNT_W=4 to reach saturation)
module tb_idex_pipe_reg;
  localparam int XLEN = 32;
  localparam int CNT_W = 4;
  logic clk = 1'b0, rst, stall, flush, id_valid;
  logic [XLEN-1:0] id_pc, id_rs1_data, id_rs2_data, id_imm, wb_data;
  logic [4:0] id_rs1, id_rs2, id_rd, wb_rd;
  logic [2:0] id_funct3;
  logic id_funct7b5, id_ALUSrc, id_MemRead, id_MemWrite, id_RegWrite, id_MemtoReg, id_Branch, wb_RegWrite;
  logic [1:0] id_ALUOp;
  logic idex_valid, idex_funct7b5, idex_ALUSrc, idex_MemRead, idex_MemWrite, idex_RegWrite, idex_MemtoReg, idex_Branch;
  logic [XLEN-1:0] idex_pc, idex_rs1_data, idex_rs2_data, idex_imm;
  logic [4:0] idex_rs1, idex_rs2, idex_rd;
  logic [2:0] idex_funct3;
  logic [1:0] idex_ALUOp;
  logic [CNT_W-1:0] bubble_cnt, flush_cnt;
  int compared = 0, mismatched = 0;
  logic [159:0] all_out, snap;

  idex_pipe_reg #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .id_valid(id_valid), .id_pc(id_pc),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm), .id_rs1(id_rs1),
    .id_rs2(id_rs2), .id_rd(id_rd), .id_funct3(id_funct3), .id_funct7b5(id_funct7b5),
    .id_ALUOp(id_ALUOp), .id_ALUSrc(id_ALUSrc), .id_MemRead(id_MemRead), .id_MemWrite(id_MemWrite),
    .id_RegWrite(id_RegWrite), .id_MemtoReg(id_MemtoReg), .id_Branch(id_Branch),
    .wb_RegWrite(wb_RegWrite), .wb_rd(wb_rd), .wb_data(wb_data),
    .idex_valid(idex_valid), .idex_pc(idex_pc), .idex_rs1_data(idex_rs1_data),
    .idex_rs2_data(idex_rs2_data), .idex_imm(idex_imm), .idex_rs1(idex_rs1), .idex_rs2(idex_rs2),
    .idex_rd(idex_rd), .idex_funct3(idex_funct3), .idex_funct7b5(idex_funct7b5),
    .idex_ALUOp(idex_ALUOp), .idex_ALUSrc(idex_ALUSrc), .idex_MemRead(idex_MemRead),
    .idex_MemWrite(idex_MemWrite), .idex_RegWrite(idex_RegWrite), .idex_MemtoReg(idex_MemtoReg),
    .idex_Branch(idex_Branch), .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  assign all_out = {4'd0, idex_valid, idex_pc, idex_rs1_data, idex_rs2_data, idex_imm, idex_rs1,
                    idex_rs2, idex_rd, idex_funct3, idex_funct7b5, idex_ALUOp, idex_ALUSrc,
                    idex_MemRead, idex_MemWrite, idex_RegWrite, idex_MemtoReg, idex_Branch};

  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id_all_ones();
    id_valid = 1; id_pc = '1; id_rs1_data = '1; id_rs2_data = '1; id_imm = '1;
    id_rs1 = '1; id_rs2 = '1; id_rd = '1; id_funct3 = '1; id_funct7b5 = 1; id_ALUOp = '1;
    id_ALUSrc = 1; id_MemRead = 1; id_MemWrite = 1; id_RegWrite = 1; id_MemtoReg = 1; id_Branch = 1;
  endtask

  task automatic set_id_zero();
    id_valid = 0; id_pc = '0; id_rs1_data = '0; id_rs2_data = '0; id_imm = '0;
    id_rs1 = '0; id_rs2 = '0; id_rd = '0; id_funct3 = '0; id_funct7b5 = 0; id_ALUOp = '0;
    id_ALUSrc = 0; id_MemRead = 0; id_MemWrite = 0; id_RegWrite = 0; id_MemtoReg = 0; id_Branch = 0;
  endtask

  initial begin
    rst = 1; stall = 0; flush = 1; wb_RegWrite = 1; wb_rd = 5'd3; wb_data = 32'h1234_5678;
    set_id_all_ones();
    tick(); tick();
    chk("reset_fields", all_out, '0);
    chk("reset_bubble_cnt", 160'(bubble_cnt), 160'd0);
    chk("reset_flush_cnt", 160'(flush_cnt), 160'd0);

    rst = 0; flush = 0; stall = 1; wb_RegWrite = 0; wb_rd = 0; wb_data = 0;
    set_id_zero();
    id_valid = 1; id_pc = 32'h0000_0100; id_rd = 5'd5; id_RegWrite = 1; id_imm = 32'hFFFF_FFF0;
    id_rs1 = 5'd2; id_rs1_data = 32'hAAAA_0001; id_funct3 = 3'b101; id_funct7b5 = 1; id_ALUOp = 2'b10;
    tick();
    chk("load_rd", 160'(idex_rd), 160'd5);
    chk("load_regwrite", 160'(idex_RegWrite), 160'd1);
    chk("load_imm", 160'(idex_imm), 160'hFFFF_FFF0);
    chk("load_pc_valid", 160'({idex_valid, idex_pc}), 160'({1'b1, 32'h0000_0100}));
    chk("load_rs1", 160'({idex_rs1, idex_rs1_data}), 160'({5'd2, 32'hAAAA_0001}));
    chk("load_fn", 160'({idex_funct3, idex_funct7b5, idex_ALUOp}), 160'({3'b101, 1'b1, 2'b10}));

    snap = all_out;
    id_pc = 32'h0000_0BAD; id_rd = 5'd9;
    #2;
    chk("no_comb_path", all_out, snap);

    set_id_zero();
    id_valid = 1; id_pc = 32'h104; id_rd = 5'd6; id_MemRead = 1; id_MemtoReg = 1; id_RegWrite = 1; id_ALUSrc = 1;
    tick();
    chk("lw_memread", 160'({idex_MemRead, idex_rd}), 160'({1'b1, 5'd6}));
    stall = 0;
    set_id_zero();
    id_valid = 1; id_pc = 32'h108; id_rs1 = 5'd6; id_rd = 5'd8; id_RegWrite = 1;
    tick();
    chk("bubble_fields", all_out, '0);
    chk("bubble_cnt_1", 160'(bubble_cnt), 160'd1);
    stall = 1;
    tick();
    chk("after_bubble_load", 160'({idex_MemRead, idex_rs1, idex_rd, idex_pc}), 160'({1'b0, 5'd6, 5'd8, 32'h108}));
    chk("bubble_cnt_hold", 160'(bubble_cnt), 160'd1);

    set_id_zero();
    id_valid = 1; id_rs1 = 5'd7; id_rs2 = 5'd7; id_rs1_data = 32'd1; id_rs2_data = 32'd2; id_ALUOp = 2'b11;
    wb_RegWrite = 1; wb_rd = 5'd7; wb_data = 32'hDEAD_BEEF;
    tick();
    chk("bypass_rs1", 160'(idex_rs1_data), 160'hDEAD_BEEF);
    chk("bypass_rs2", 160'(idex_rs2_data), 160'hDEAD_BEEF);
    wb_rd = 5'd0;
    tick();
    chk("bypass_x0_rs1", 160'(idex_rs1_data), 160'd1);
    chk("bypass_x0_rs2", 160'(idex_rs2_data), 160'd2);
    wb_rd = 5'd7; id_rs2 = 5'd8;
    tick();
    chk("bypass_only_rs1", 160'({idex_rs1_data, idex_rs2_data}), 160'({32'hDEAD_BEEF, 32'd2}));
    id_rs1 = 5'd9; id_rs2 = 5'd7;
    tick();
    chk("bypass_only_rs2", 160'({idex_rs1_data, idex_rs2_data}), 160'({32'd1, 32'hDEAD_BEEF}));
    wb_RegWrite = 0;
    tick();
    chk("bypass_nowrite", 160'(idex_rs2_data), 160'd2);

    set_id_all_ones();
    flush = 1; stall = 0;
    tick();
    chk("flush_fields", all_out, '0);
    chk("flush_cnt_1", 160'(flush_cnt), 160'd1);
    chk("flush_bubble_unchanged", 160'(bubble_cnt), 160'd1);

    flush = 0; stall = 0;
    for (int i = 0; i < 13; i++) tick();
    chk("bubble_cnt_14", 160'(bubble_cnt), 160'd14);
    for (int i = 0; i < 7; i++) tick();
    chk("bubble_cnt_sat", 160'(bubble_cnt), 160'd15);
    chk("sat_fields_zero", all_out, '0);

    rst = 1; flush = 1;
    tick();
    chk("rst_bubble_cnt", 160'(bubble_cnt), 160'd0);
    chk("rst_flush_cnt", 160'(flush_cnt), 160'd0);
    rst = 0; flush = 0; stall = 1;
    tick();
    chk("post_rst_load", 160'({idex_valid, idex_rd, idex_pc}), 160'({1'b1, 5'h1F, 32'hFFFF_FFFF}));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
